// File: rtl/mealy_overlap_10110.sv
// Overlapping Mealy detector for the serial pattern 1-0-1-1-0 (oldest bit first).
// Optional saturating match counter on port match_cnt, enabled by defining MATCH_COUNT_EN.
module mealy_overlap_10110 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_data,
`ifdef MATCH_COUNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             out_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    if (CNT_W < 1) begin : g_invalid_cnt_w
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Each state is the longest received suffix that is also a prefix of 10110;
    // a match falls back to S10 so the trailing "10" seeds the next detection.
    always_comb begin
        next_state = IDLE;
        out_data   = 1'b0;
        case (state)
            IDLE:  next_state = in_data ? S1 : IDLE;
            S1:    next_state = in_data ? S1 : S10;
            S10:   next_state = in_data ? S101 : IDLE;
            S101:  next_state = in_data ? S1011 : S10;
            S1011: begin
                next_state = in_data ? S1 : S10;
                out_data   = ~in_data;
            end
            default: begin
                next_state = IDLE;
                out_data   = 1'b0;
            end
        endcase
    end

`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt;

    // Counts consumed matches and holds at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (out_data && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign match_cnt = cnt;
`endif

endmodule

// File: tb/tb_mealy_overlap_10110.sv
// Self-checking bench for mealy_overlap_10110: vector table, hand-written corner sequences,
// and a random stream checked against a bit-history model; counter checks when MATCH_COUNT_EN is defined.
module tb_mealy_overlap_10110;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic in_data;
    logic out_data;
`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    always #5 clk = ~clk;

`ifdef MATCH_COUNT_EN
    mealy_overlap_10110 #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .match_cnt (match_cnt),
        .out_data  (out_data)
    );
`else
    mealy_overlap_10110 dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .out_data (out_data)
    );
`endif

    typedef struct {
        logic rst;
        logic din;
        logic exp;
    } vec_t;

    vec_t vecs[$];
    logic exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [3:0] hist;
    int         nbits;
    int         model_cnt;

    function automatic logic model_out(input logic r, input logic d);
        return r && (nbits >= 4) && ({hist, d} == 5'b10110);
    endfunction

    task automatic checkOutput(input string name);
        logic exp;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: scoreboard empty, out_data=%0b", name, out_data);
        end else begin
            exp = exp_q.pop_front();
            if (out_data !== exp) begin
                tests_failed++;
                $display("[TB] FAIL %s: out_data=%0b required %0b (t=%0t)", name, out_data, exp, $time);
            end
        end
`ifdef MATCH_COUNT_EN
        tests_run++;
        if (int'(match_cnt) != model_cnt) begin
            tests_failed++;
            $display("[TB] FAIL %s cnt: match_cnt=%0d required %0d (t=%0t)", name, match_cnt, model_cnt, $time);
        end
`endif
    endtask

    // Drive one bit away from the rising edge, check, then let the edge consume it.
    task automatic applyStimulus(input logic r, input logic d, input logic exp, input string name);
        @(negedge clk);
        rst     = r;
        in_data = d;
        exp_q.push_back(exp);
        if (!r) begin
            hist      = '0;
            nbits     = 0;
            model_cnt = 0;
        end
        #1;
        checkOutput(name);
        if (r) begin
            if (exp && model_cnt < CNT_MAX) model_cnt++;
            hist = {hist[2:0], d};
            nbits++;
        end
    endtask

    task automatic applySequence(input string bits, input string name);
        logic d;
        for (int i = 0; i < bits.len(); i++) begin
            d = (bits[i] == "1");
            applyStimulus(1'b1, d, model_out(1'b1, d), name);
        end
    endtask

    task automatic addVec(input logic r, input logic d, input logic e);
        vec_t v;
        v.rst = r;
        v.din = d;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic d;
        rst       = 1'b0;
        in_data   = 1'b0;
        hist      = '0;
        nbits     = 0;
        model_cnt = 0;

        // reset held with toggling input
        addVec(0, 0, 0); addVec(0, 1, 0); addVec(0, 0, 0);
        // single match then quiet
        addVec(1, 1, 0); addVec(1, 0, 0); addVec(1, 1, 0); addVec(1, 1, 0); addVec(1, 0, 1);
        addVec(1, 0, 0); addVec(1, 0, 0); addVec(1, 0, 0);
        // overlap 10110110
        addVec(1, 1, 0); addVec(1, 0, 0); addVec(1, 1, 0); addVec(1, 1, 0); addVec(1, 0, 1);
        addVec(1, 1, 0); addVec(1, 1, 0); addVec(1, 0, 1);
        addVec(1, 0, 0); addVec(1, 0, 0);
        // near miss 1010110 through S101->S10
        addVec(1, 1, 0); addVec(1, 0, 0); addVec(1, 1, 0); addVec(1, 0, 0); addVec(1, 1, 0);
        addVec(1, 1, 0); addVec(1, 0, 1);
        addVec(1, 0, 0); addVec(1, 0, 0);
        // near miss 101110
        addVec(1, 1, 0); addVec(1, 0, 0); addVec(1, 1, 0); addVec(1, 1, 0); addVec(1, 1, 0);
        addVec(1, 0, 0);
        addVec(1, 0, 0); addVec(1, 0, 0);
        // mid-sequence reset while sitting in 1011 with in_data=0
        addVec(1, 1, 0); addVec(1, 0, 0); addVec(1, 1, 0); addVec(1, 1, 0);
        addVec(0, 0, 0);
        addVec(1, 0, 0);
        addVec(1, 1, 0); addVec(1, 0, 0); addVec(1, 1, 0); addVec(1, 1, 0); addVec(1, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // counter saturation run: five back-to-back overlapping matches from reset
        applyStimulus(1'b0, 1'b1, 1'b0, "sat_reset");
        applySequence("101101101101101100", "sat_run");

        // triple overlap preceded by partial prefixes
        applyStimulus(1'b0, 1'b0, 1'b0, "ovl_reset");
        applySequence("1101011011011000", "ovl_run");

        // random stream against the history model
        for (int i = 0; i < 300; i++) begin
            d = logic'($urandom_range(0, 1));
            if (i % 97 == 50) begin
                applyStimulus(1'b0, d, 1'b0, "rand_reset");
            end else begin
                applyStimulus(1'b1, d, model_out(1'b1, d), "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
